// File: rtl/bitwave_pkg.sv
// Shared types and defaults for the bitwave shift-accumulate lane.
// BW_ACC_SAT_EN selects saturating (defined) or wrapping (undefined) accumulation.
package bitwave_pkg;

  localparam int unsigned BW_PSUM_W    = 12;
  localparam int unsigned BW_ACC_W     = 20;
  localparam int unsigned BW_MAX_SHIFT = 6;

`ifdef BW_ACC_SAT_EN
  localparam bit BW_SAT_EN = 1'b1;
`else
  localparam bit BW_SAT_EN = 1'b0;
`endif

  typedef enum logic {
    StAcc,
    StWait
  } bw_state_e;

endpackage

// File: rtl/bitwave_sat_add.sv
// Signed ACC_W adder with overflow flag; clamps to signed min/max when BW_ACC_SAT_EN
// is defined, otherwise wraps.
module bitwave_sat_add
  import bitwave_pkg::*;
#(
  parameter int unsigned ACC_W = BW_ACC_W
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

  logic signed [ACC_W:0] w_wide;

  assign w_wide = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};
  assign o_ovf  = w_wide[ACC_W] ^ w_wide[ACC_W-1];

`ifdef BW_ACC_SAT_EN
  always_comb begin
    o_sum = w_wide[ACC_W-1:0];
    // The extra sign bit tells which rail was crossed.
    if (o_ovf) begin
      o_sum = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign o_sum = w_wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/bitwave_shift_acc.sv
// Per-lane shift-accumulate: sums shifted bit-column partial sums and hands the dot product
// to a one-deep valid/ready output register. Saturation selected by BW_ACC_SAT_EN.
module bitwave_shift_acc
  import bitwave_pkg::*;
#(
  parameter int unsigned PSUM_W = BW_PSUM_W,
  parameter int unsigned ACC_W  = BW_ACC_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [PSUM_W-1:0] i_psum_in,
  input  logic                     i_neg,
  input  logic [2:0]               i_shift_offset,
  input  logic                     i_valid,
  input  logic                     i_done,
  output logic                     o_in_ready,
  output logic signed [ACC_W-1:0]  o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_sat_flag
);

  bw_state_e               r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_out_data;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_sat_flag;

  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_addend;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_illegal;
  logic                    w_ovf;
  logic                    w_accept;
  logic                    w_sat_evt;
  logic                    w_drain;

  assign w_ext     = {{(ACC_W-PSUM_W){i_psum_in[PSUM_W-1]}}, i_psum_in};
  assign w_illegal = i_shift_offset > 3'(BW_MAX_SHIFT);
  assign w_shifted = w_ext << i_shift_offset;
  assign w_term    = i_neg ? -w_shifted : w_shifted;
  // A done-only cycle or an illegal offset contributes nothing to the sum.
  assign w_addend  = (i_valid && !w_illegal) ? w_term : '0;
  assign w_accept  = r_in_ready && (i_valid || i_done);
  assign w_sat_evt = i_valid && (w_illegal || (BW_SAT_EN && w_ovf));
  assign w_drain   = r_out_valid && i_out_ready;

  bitwave_sat_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .i_a  (r_acc),
    .i_b  (w_addend),
    .o_sum(w_sum),
    .o_ovf(w_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StAcc;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sat_flag  <= 1'b0;
    end else begin
      unique case (r_state)
        StAcc: begin
          if (w_drain) r_out_valid <= 1'b0;
          if (w_accept) begin
            if (w_sat_evt) r_sat_flag <= 1'b1;
            if (i_done && r_out_valid && !i_out_ready) begin
              // Output slot still occupied: park the final sum in acc.
              r_acc      <= w_sum;
              r_state    <= StWait;
              r_in_ready <= 1'b0;
            end else if (i_done) begin
              r_out_data  <= w_sum;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
            end else begin
              r_acc <= w_sum;
            end
          end
        end
        StWait: begin
          if (i_out_ready) begin
            r_out_data <= r_acc;
            r_acc      <= '0;
            r_state    <= StAcc;
            r_in_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_bitwave_shift_acc.sv
// Self-checking bench for bitwave_shift_acc: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference of the lane's behaviour.
module tb_bitwave_shift_acc;

  localparam int PW = 12;
  localparam int AW = 20;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [PW-1:0] psum;
  logic                 neg;
  logic [2:0]           off;
  logic                 valid;
  logic                 done;
  logic                 in_ready;
  logic signed [AW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sat;

  int checks   = 0;
  int failures = 0;

  // Reference state
  longint m_acc, m_out;
  bit     m_ov, m_wait, m_sat;

  bitwave_shift_acc dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_psum_in     (psum),
    .i_neg         (neg),
    .i_shift_offset(off),
    .i_valid       (valid),
    .i_done        (done),
    .o_in_ready    (in_ready),
    .o_out_data    (out_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_sat_flag    (sat)
  );

  always #5 clk = ~clk;

  task automatic fold(input longint v, output longint r);
    longint hi, lo, span;
    hi   = (64'sd1 <<< (AW - 1)) - 1;
    lo   = -(64'sd1 <<< (AW - 1));
    span = 64'sd1 <<< AW;
`ifdef BW_ACC_SAT_EN
    if (v > hi) begin r = hi; m_sat = 1'b1; end
    else if (v < lo) begin r = lo; m_sat = 1'b1; end
    else r = v;
`else
    r = v % span;
    if (r > hi) r = r - span;
    if (r < lo) r = r + span;
`endif
  endtask

  task automatic model_tick();
    longint term, sum;
    if (rst) begin
      m_acc = 0; m_out = 0; m_ov = 0; m_wait = 0; m_sat = 0;
      return;
    end
    if (m_wait) begin
      if (out_ready) begin m_out = m_acc; m_acc = 0; m_wait = 0; end
      return;
    end
    term = 0;
    if (valid) begin
      if (off == 3'd7) m_sat = 1'b1;
      else begin
        term = longint'(psum) * (64'sd1 <<< off);
        if (neg) term = -term;
      end
    end
    if (valid || done) begin
      fold(m_acc + term, sum);
      if (done) begin
        if (m_ov && !out_ready) begin m_acc = sum; m_wait = 1'b1; end
        else begin m_out = sum; m_ov = 1'b1; m_acc = 0; end
      end else begin
        m_acc = sum;
        if (m_ov && out_ready) m_ov = 1'b0;
      end
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit d, input int p, input int o, input bit n,
                       input bit r);
    valid = v; done = d; psum = PW'(p); off = 3'(o); neg = n; out_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 123, 3, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got %0b want 0", sat); end
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 0, 5, 0, 0, 1); tick();
    drive(1, 0, 3, 2, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 1); tick();
    checks++; if (out_data !== 20'sd17) begin failures++; $display("FAIL basic_data got %0d want 17", out_data); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    drive(0, 0, 0, 0, 0, 1); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got %0b want 0", out_valid); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL basic_sat got %0b want 0", sat); end
  endtask

  task automatic test_done_with_valid();
    do_reset();
    drive(1, 0, 5, 1, 0, 1); tick();
    drive(1, 1, -4, 6, 0, 1); tick();
    checks++; if (out_data !== -20'sd246) begin failures++; $display("FAIL dwv_data got %0d want -246", out_data); end
    drive(1, 0, 1, 0, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 1); tick();
    checks++; if (out_data !== 20'sd1) begin failures++; $display("FAIL dwv_restart got %0d want 1", out_data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 7, 0, 0, 0); tick();
    checks++; if (out_data !== 20'sd7) begin failures++; $display("FAIL bp_a got %0d want 7", out_data); end
    drive(1, 1, 2, 1, 0, 0); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
    checks++; if (out_data !== 20'sd7) begin failures++; $display("FAIL bp_hold got %0d want 7", out_data); end
    drive(1, 1, 100, 0, 0, 0); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_still_wait got %0b want 0", in_ready); end
    drive(0, 0, 0, 0, 0, 1); tick();
    checks++; if (out_data !== 20'sd4) begin failures++; $display("FAIL bp_b got %0d want 4", out_data); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_b_valid got %0b want 1", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_resume got %0b want 1", in_ready); end
    drive(0, 0, 0, 0, 0, 1); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_done_alone();
    do_reset();
    drive(0, 1, 0, 0, 0, 1); tick();
    checks++; if (out_data !== '0) begin failures++; $display("FAIL alone_data got %0d want 0", out_data); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL alone_valid got %0b want 1", out_valid); end
  endtask

  task automatic test_saturate();
    logic signed [AW-1:0] want;
    bit                   want_sat;
`ifdef BW_ACC_SAT_EN
    want = 20'sd524287; want_sat = 1'b1;
`else
    want = 20'sd523008; want_sat = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 20; i++) begin drive(1, 0, 2047, 6, 0, 1); tick(); end
    drive(0, 1, 0, 0, 0, 1); tick();
    checks++; if (out_data !== want) begin failures++; $display("FAIL sat_data got %0d want %0d", out_data, want); end
    checks++; if (sat !== want_sat) begin failures++; $display("FAIL sat_flag got %0b want %0b", sat, want_sat); end
  endtask

  task automatic test_illegal_and_reset();
    do_reset();
    drive(1, 0, 100, 7, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 1); tick();
    checks++; if (out_data !== '0) begin failures++; $display("FAIL illegal_data got %0d want 0", out_data); end
    checks++; if (sat !== 1'b1) begin failures++; $display("FAIL illegal_sat got %0b want 1", sat); end
    drive(1, 0, 5, 0, 0, 0); tick();
    rst = 1'b1; drive(1, 0, 9, 1, 0, 0); tick(); rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL midrst_data got %0d want 0", out_data); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL midrst_sat got %0b want 0", sat); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got %0b want 1", in_ready); end
    drive(0, 1, 0, 0, 0, 1); tick();
    checks++; if (out_data !== '0) begin failures++; $display("FAIL midrst_discard got %0d want 0", out_data); end
  endtask

  task automatic test_random();
    logic signed [AW-1:0] e_d;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 6) == 0, int'($urandom),
            ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, 6)),
            1'($urandom), $urandom_range(0, 2) != 0);
      tick();
      e_d = m_out[AW-1:0];
      checks++; if (out_data !== e_d) begin failures++; $display("FAIL rand_data cyc %0d got %0d want %0d", c, out_data, e_d); end
      checks++; if (out_valid !== m_ov) begin failures++; $display("FAIL rand_valid cyc %0d got %0b want %0b", c, out_valid, m_ov); end
      checks++; if (in_ready !== !m_wait) begin failures++; $display("FAIL rand_ready cyc %0d got %0b want %0b", c, in_ready, !m_wait); end
      checks++; if (sat !== m_sat) begin failures++; $display("FAIL rand_sat cyc %0d got %0b want %0b", c, sat, m_sat); end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_done_with_valid();
    test_back_to_back();
    test_done_alone();
    test_saturate();
    test_illegal_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
